// File: rtl/execute_stage.sv
// execute_stage: combinational RV32I execute stage with forwarding from the
// EX/MEM (FA/AA) and MEM/WB (FM/AM) boundaries, ALU, branch compare and PC+4.
// Ports: IR/Imm/A/B/PC in, FA/FM/AA/AM forwarding in, clk/rst,
//        v_in/r_in/stall handshake in; IR_res/ALU_res/COMP_res/PC_res/B_res,
//        v_out/r_out out. Only the handshake enable flop is sequential.
module execute_stage (
    input  logic [31:0] IR,
    input  logic [31:0] Imm,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] PC,
    input  logic [31:0] FA,
    input  logic [31:0] FM,
    input  logic [4:0]  AA,
    input  logic [4:0]  AM,
    input  logic        clk,
    output logic [31:0] IR_res,
    output logic [31:0] ALU_res,
    output logic        COMP_res,
    output logic [31:0] PC_res,
    output logic [31:0] B_res,
    input  logic        v_in,
    output logic        v_out,
    input  logic        r_in,
    output logic        r_out,
    input  logic        stall,
    input  logic        rst
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] arith;
    logic        en;

    assign opcode = IR[6:0];
    assign funct3 = IR[14:12];
    assign rs1    = IR[19:15];
    assign rs2    = IR[24:20];
    assign alt    = IR[30];

    // If/else chains: an unknown AA/AM compare is not taken, so it
    // falls through to the register-file value.
    always_comb begin
        op_a = A;
        if (rs1 != 5'd0 && AA == rs1) begin
            op_a = FA;
        end else if (rs1 != 5'd0 && AM == rs1) begin
            op_a = FM;
        end
    end

    always_comb begin
        op_b = B;
        if (rs2 != 5'd0 && AA == rs2) begin
            op_b = FA;
        end else if (rs2 != 5'd0 && AM == rs2) begin
            op_b = FM;
        end
    end

    assign op2   = (opcode == OP_REG) ? op_b : Imm;
    assign shamt = op2[4:0];

    always_comb begin
        arith = 32'd0;
        unique case (funct3)
            3'b000: begin
                if (opcode == OP_REG && alt) arith = op_a - op2;
                else                         arith = op_a + op2;
            end
            3'b001: arith = op_a << shamt;
            3'b010: arith = {31'd0, $signed(op_a) < $signed(op2)};
            3'b011: arith = {31'd0, op_a < op2};
            3'b100: arith = op_a ^ op2;
            3'b101: begin
                if (alt) arith = 32'($signed(op_a) >>> shamt);
                else     arith = op_a >> shamt;
            end
            3'b110: arith = op_a | op2;
            3'b111: arith = op_a & op2;
            default: arith = 32'd0;
        endcase
    end

    always_comb begin
        ALU_res = 32'd0;
        unique case (opcode)
            OP_LUI:    ALU_res = Imm;
            OP_AUIPC:  ALU_res = PC + Imm;
            OP_JAL:    ALU_res = PC + Imm;
            OP_JALR:   ALU_res = (op_a + Imm) & 32'hFFFF_FFFE;
            OP_BRANCH: ALU_res = PC + Imm;
            OP_LOAD:   ALU_res = op_a + Imm;
            OP_STORE:  ALU_res = op_a + Imm;
            OP_IMM:    ALU_res = arith;
            OP_REG:    ALU_res = arith;
            default:   ALU_res = 32'd0;
        endcase
    end

    always_comb begin
        COMP_res = 1'b0;
        if (opcode == OP_BRANCH) begin
            unique case (funct3)
                3'b000: COMP_res = (op_a == op_b);
                3'b001: COMP_res = (op_a != op_b);
                3'b100: COMP_res = ($signed(op_a) < $signed(op_b));
                3'b101: COMP_res = ($signed(op_a) >= $signed(op_b));
                3'b110: COMP_res = (op_a < op_b);
                3'b111: COMP_res = (op_a >= op_b);
                default: COMP_res = 1'b0;
            endcase
        end else if (opcode == OP_JAL || opcode == OP_JALR) begin
            COMP_res = 1'b1;
        end
    end

    assign PC_res = PC + 32'd4;
    assign IR_res = IR;
    assign B_res  = op_b;

    always_ff @(posedge clk) begin
        if (rst) en <= 1'b0;
        else     en <= 1'b1;
    end

    assign v_out = en & v_in & ~stall;
    assign r_out = en & r_in & ~stall;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver pushes expected responses,
// a monitor on the falling edge pops and compares them.
module tb_execute_stage;

    logic [31:0] IR, Imm, A, B, PC, FA, FM;
    logic [4:0]  AA, AM;
    logic        clk, rst, v_in, r_in, stall;
    logic [31:0] IR_res, ALU_res, PC_res, B_res;
    logic        COMP_res, v_out, r_out;

    execute_stage dut (
        .IR(IR), .Imm(Imm), .A(A), .B(B), .PC(PC), .FA(FA), .FM(FM),
        .AA(AA), .AM(AM), .clk(clk), .IR_res(IR_res), .ALU_res(ALU_res),
        .COMP_res(COMP_res), .PC_res(PC_res), .B_res(B_res),
        .v_in(v_in), .v_out(v_out), .r_in(r_in), .r_out(r_out),
        .stall(stall), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] ir, alu, pc, b;
        logic        comp, v, r;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic en_m = 1'b0;
    int   id_cnt = 0;

    function automatic logic [31:0] mk(input logic [6:0] opc,
                                       input logic [2:0] f3,
                                       input logic [4:0] r1,
                                       input logic [4:0] r2,
                                       input logic al);
        logic [31:0] w;
        w = 32'd0;
        w[6:0] = opc;
        w[11:7] = 5'd5;
        w[14:12] = f3;
        w[19:15] = r1;
        w[24:20] = r2;
        w[30] = al;
        return w;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r,
                                        input logic [31:0] reg_v);
        if (r != 0 && AA == r) return FA;
        if (r != 0 && AM == r) return FM;
        return reg_v;
    endfunction

    function automatic logic lt_s(input logic [31:0] x, input logic [31:0] y);
        if (x[31] != y[31]) return x[31];
        return x < y;
    endfunction

    function automatic logic [31:0] calc(input int f3, input bit is_sub,
                                         input bit al, input logic [31:0] x,
                                         input logic [31:0] y);
        int s;
        logic [31:0] t;
        s = int'(y % 32);
        case (f3)
            0: return is_sub ? x - y : x + y;
            1: return x << s;
            2: return {31'd0, lt_s(x, y)};
            3: return {31'd0, x < y};
            4: return x ^ y;
            5: begin
                t = x >> s;
                if (al && x[31]) t = t | ~(32'hFFFF_FFFF >> s);
                return t;
            end
            6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] a,
                                          input logic [31:0] b);
        int f3;
        f3 = int'(IR[14:12]);
        case (IR[6:0])
            7'h37: return Imm;
            7'h17, 7'h6F, 7'h63: return PC + Imm;
            7'h67: return (a + Imm) & 32'hFFFF_FFFE;
            7'h03, 7'h23: return a + Imm;
            7'h13: return calc(f3, 1'b0, IR[30], a, Imm);
            7'h33: return calc(f3, IR[30], IR[30], a, b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_comp(input logic [31:0] a,
                                    input logic [31:0] b);
        if (IR[6:0] == 7'h6F || IR[6:0] == 7'h67) return 1'b1;
        if (IR[6:0] != 7'h63) return 1'b0;
        case (IR[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return lt_s(a, b);
            3'd5: return !lt_s(a, b);
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    // Advance one cycle; en_m tracks the rst value seen at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        en_m = !rst;
    endtask

    task automatic push(input bit use_const, input logic [31:0] ealu,
                        input logic ecomp);
        exp_t e;
        logic [31:0] a, b;
        #1;
        a = fwd(IR[19:15], A);
        b = fwd(IR[24:20], B);
        id_cnt++;
        e.id = id_cnt;
        e.ir = IR;
        e.alu = use_const ? ealu : m_alu(a, b);
        e.comp = use_const ? ecomp : m_comp(a, b);
        e.pc = PC + 32'd4;
        e.b = b;
        e.v = en_m & v_in & ~stall;
        e.r = en_m & r_in & ~stall;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("IR_res", e.id, IR_res, e.ir);
                chk("ALU_res", e.id, ALU_res, e.alu);
                chk("COMP_res", e.id, {31'd0, COMP_res}, {31'd0, e.comp});
                chk("PC_res", e.id, PC_res, e.pc);
                chk("B_res", e.id, B_res, e.b);
                chk("v_out", e.id, {31'd0, v_out}, {31'd0, e.v});
                chk("r_out", e.id, {31'd0, r_out}, {31'd0, e.r});
            end
        end
    end

    task automatic base();
        Imm = 0; A = 0; B = 0; PC = 32'h100; FA = 0; FM = 0;
        AA = 0; AM = 0; v_in = 1; r_in = 1; stall = 0; rst = 0;
    endtask

    localparam logic [6:0] OI = 7'h13, OR = 7'h33, BR = 7'h63;

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        base();
        IR = mk(OI, 0, 1, 2, 0);
        rst = 1;
        tick();
        // Reset seen at this edge: handshake must be low with v_in=1.
        push(1'b0, 0, 0);
        tick();
        push(1'b0, 0, 0);
        rst = 0;
        tick();
        push(1'b0, 0, 0);
        tick();
        // Released: v_out/r_out high.
        base(); IR = mk(OI, 0, 1, 2, 0); A = 5; Imm = -7;
        push(1'b1, 32'hFFFF_FFFE, 0);
        tick();
        base(); IR = mk(OR, 0, 1, 2, 1); A = 3; B = 10;
        push(1'b1, 32'hFFFF_FFF9, 0);
        tick();
        base(); IR = mk(OR, 5, 1, 2, 1); A = 32'h8000_0010; B = 4;
        stall = 1;
        push(1'b1, 32'hF800_0001, 0);
        tick();
        base(); IR = mk(OR, 5, 1, 2, 0); A = 32'h8000_0010; B = 4;
        push(1'b1, 32'h0800_0001, 0);
        tick();
        base(); IR = mk(OI, 1, 1, 2, 0); A = 1; Imm = 35;
        push(1'b1, 32'd8, 0);
        tick();
        base(); IR = mk(BR, 4, 1, 2, 0); A = 32'hFFFF_FFFF; B = 1;
        Imm = 32'h20;
        push(1'b1, 32'h120, 1);
        tick();
        base(); IR = mk(BR, 6, 1, 2, 0); A = 32'hFFFF_FFFF; B = 1;
        Imm = 32'h20;
        push(1'b1, 32'h120, 0);
        tick();
        base(); IR = mk(BR, 7, 1, 2, 0); A = 32'hFFFF_FFFF; B = 1;
        Imm = 32'h20;
        push(1'b1, 32'h120, 1);
        tick();
        base(); IR = mk(BR, 0, 1, 2, 0); A = 9; B = 9; Imm = 32'h20;
        push(1'b1, 32'h120, 1);
        tick();
        base(); IR = mk(BR, 2, 1, 2, 0); A = 32'hFFFF_FFFF; B = 1;
        Imm = 32'h20;
        push(1'b1, 32'h120, 0);
        tick();
        base(); IR = mk(OR, 0, 1, 2, 0); A = 7; B = 5; AA = 1; FA = 100;
        push(1'b1, 32'd105, 0);
        tick();
        base(); IR = mk(OR, 0, 1, 2, 0); A = 7; B = 5; AA = 1; FA = 100;
        AM = 1; FM = 50;
        push(1'b1, 32'd105, 0);
        tick();
        base(); IR = mk(OR, 0, 0, 2, 0); A = 7; B = 5; AA = 0; FA = 100;
        push(1'b1, 32'd12, 0);
        tick();
        base(); IR = mk(OR, 0, 1, 2, 0); A = 7; B = 5; AM = 2; FM = 32'h55;
        push(1'b1, 32'h5C, 0);
        tick();
        base(); IR = mk(7'h67, 0, 1, 2, 0); A = 32'h1001; Imm = 2;
        PC = 32'h200;
        push(1'b1, 32'h1002, 1);
        tick();
        base(); IR = mk(7'h7F, 0, 1, 2, 0); A = 32'h1234; Imm = 9;
        push(1'b1, 32'd0, 0);
        for (int i = 0; i < 400; i++) begin
            tick();
            IR = mk(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            IR[31] = 1'($urandom_range(0, 1));
            Imm = $urandom; A = $urandom; B = $urandom;
            if ($urandom_range(0, 3) == 0) B = A;
            PC = $urandom; FA = $urandom; FM = $urandom;
            AA = 5'($urandom_range(0, 4));
            AM = 5'($urandom_range(0, 4));
            v_in = 1'($urandom_range(0, 1));
            r_in = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 19) == 0);
            push(1'b0, 0, 0);
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
